// File: rtl/mem_refill_arbiter_if.sv
// Bundle of every handshake/data signal between the refill arbiter, the two
// cache miss handlers and the external memory port.
//   slave  : arbiter view (drives *_ready, *_rvalid, *_done, mem_* requests)
//   master : environment view (caches + memory model drive the other side)
interface mem_refill_arbiter_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  // I-cache refill path
  logic                  ic_req_valid;
  logic [ADDR_WIDTH-1:0] ic_req_addr;
  logic                  ic_req_ready;
  logic [DATA_WIDTH-1:0] ic_rdata;
  logic                  ic_rvalid;
  logic                  ic_done;
  // D-cache refill / writeback path
  logic                  dc_req_valid;
  logic                  dc_req_write;
  logic [ADDR_WIDTH-1:0] dc_req_addr;
  logic                  dc_req_ready;
  logic [DATA_WIDTH-1:0] dc_wdata;
  logic                  dc_wready;
  logic [DATA_WIDTH-1:0] dc_rdata;
  logic                  dc_rvalid;
  logic                  dc_done;
  // external memory port
  logic                  mem_req_valid;
  logic                  mem_req_write;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_ready;
  logic                  mem_wvalid;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;
  logic                  proto_err;

  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_rdata, ic_rvalid, ic_done,
    input  dc_req_valid, dc_req_write, dc_req_addr, dc_wdata,
    output dc_req_ready, dc_wready, dc_rdata, dc_rvalid, dc_done,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_wvalid, mem_wdata,
    input  mem_req_ready, mem_wready, mem_rdata, mem_rvalid,
    output proto_err
  );

  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_rdata, ic_rvalid, ic_done,
    output dc_req_valid, dc_req_write, dc_req_addr, dc_wdata,
    input  dc_req_ready, dc_wready, dc_rdata, dc_rvalid, dc_done,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_wvalid, mem_wdata,
    output mem_req_ready, mem_wready, mem_rdata, mem_rvalid,
    input  proto_err
  );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter sharing one external memory port between the I-cache
// refill path and the D-cache refill/writeback path. One requester owns the
// port for a whole line burst: IDLE (arbitrate) -> ADDR -> LINE_WORDS beats
// (RDATA or WDATA) -> DONE -> IDLE.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : mem_refill_arbiter_if.slave (cache request/response + memory port)
module mem_refill_arbiter #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  mem_refill_arbiter_if.slave bus
);

  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef struct packed {
    logic                  owner;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
  } grant_t;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  grant_t        gnt;
  logic          last_grant;
  logic          proto_err_q;

  logic in_addr, in_rd, in_wr, in_done;
  logic pick_dc, rd_beat, wr_beat, own_ic, own_dc;

  assign in_addr = (state == S_ADDR);
  assign in_rd   = (state == S_RDATA);
  assign in_wr   = (state == S_WDATA);
  assign in_done = (state == S_DONE);
  assign own_ic  = (gnt.owner == OWN_IC);
  assign own_dc  = (gnt.owner == OWN_DC);

  // D-cache wins when alone, or on a tie when the I-cache went last.
  assign pick_dc = bus.dc_req_valid & (~bus.ic_req_valid | (last_grant == OWN_IC));

  assign rd_beat = in_rd & bus.mem_rvalid;
  assign wr_beat = in_wr & bus.mem_wready;

  // Address phase, driven straight from the registered grant.
  assign bus.mem_req_valid = in_addr;
  assign bus.mem_req_write = in_addr & gnt.write;
  assign bus.mem_req_addr  = in_addr ? gnt.addr : '0;
  assign bus.ic_req_ready  = in_addr & bus.mem_req_ready & own_ic;
  assign bus.dc_req_ready  = in_addr & bus.mem_req_ready & own_dc;

  // Read beats forwarded with zero latency; the buses stay 0 when not owned.
  assign bus.ic_rvalid = rd_beat & own_ic;
  assign bus.dc_rvalid = rd_beat & own_dc;
  assign bus.ic_rdata  = bus.ic_rvalid ? bus.mem_rdata : '0;
  assign bus.dc_rdata  = bus.dc_rvalid ? bus.mem_rdata : '0;

  // Writeback beats pass straight through; only the D-cache ever writes.
  assign bus.mem_wvalid = in_wr;
  assign bus.mem_wdata  = in_wr ? bus.dc_wdata : '0;
  assign bus.dc_wready  = wr_beat;

  assign bus.ic_done   = in_done & own_ic;
  assign bus.dc_done   = in_done & own_dc;
  assign bus.proto_err = proto_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      gnt         <= '0;
      last_grant  <= OWN_IC;
      proto_err_q <= 1'b0;
    end else begin
      // Stray read beats are dropped but remembered until reset.
      if (bus.mem_rvalid && !in_rd) proto_err_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.ic_req_valid || bus.dc_req_valid) begin
            gnt.owner <= pick_dc;
            gnt.write <= pick_dc & bus.dc_req_write;
            gnt.addr  <= pick_dc ? bus.dc_req_addr : bus.ic_req_addr;
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus.mem_req_ready) state <= gnt.write ? S_WDATA : S_RDATA;
        end
        S_RDATA: begin
          if (rd_beat) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) state <= S_DONE;
          end
        end
        S_WDATA: begin
          if (wr_beat) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) state <= S_DONE;
          end
        end
        S_DONE: begin
          last_grant <= gnt.owner;
          cnt        <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
module tb_mem_refill_arbiter;

  localparam int AW = 26;
  localparam int DW = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_refill_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ic_req_valid  = 1'b0;
    bus.ic_req_addr   = '0;
    bus.dc_req_valid  = 1'b0;
    bus.dc_req_write  = 1'b0;
    bus.dc_req_addr   = '0;
    bus.dc_wdata      = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_wready    = 1'b0;
    bus.mem_rdata     = '0;
    bus.mem_rvalid    = 1'b0;
  endtask

  // Single read burst starting in IDLE with requests already driven.
  // exp_dc selects the expected owner; drop releases its valid after ready.
  task automatic rd_burst(input bit exp_dc, input logic [AW-1:0] exp_addr,
                          input logic [DW-1:0] base, input int stall, input bit drop);
    logic own_rv, oth_rv, own_rdy, oth_rdy, own_dn, oth_dn;
    logic [DW-1:0] own_rd;
    #1;
    checks++;
    if (bus.mem_req_valid !== 1'b0) begin
      failures++; $display("FAIL idle_req_valid got=%b exp=0", bus.mem_req_valid);
    end
    cyc();
    for (int s = 0; s < stall; s++) begin
      bus.mem_req_ready = 1'b0;
      #1;
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== exp_addr ||
          bus.ic_req_ready !== 1'b0 || bus.dc_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL addr_stall cyc=%0d valid=%b addr=%h icr=%b dcr=%b exp valid=1 addr=%h rdy=0",
                 s, bus.mem_req_valid, bus.mem_req_addr, bus.ic_req_ready, bus.dc_req_ready, exp_addr);
      end
      cyc();
    end
    bus.mem_req_ready = 1'b1;
    #1;
    own_rdy = exp_dc ? bus.dc_req_ready : bus.ic_req_ready;
    oth_rdy = exp_dc ? bus.ic_req_ready : bus.dc_req_ready;
    checks++;
    if (own_rdy !== 1'b1 || oth_rdy !== 1'b0 || bus.mem_req_addr !== exp_addr ||
        bus.mem_req_write !== 1'b0) begin
      failures++;
      $display("FAIL addr_accept own_rdy=%b oth_rdy=%b addr=%h wr=%b exp 1 0 %h 0 (dc=%0d)",
               own_rdy, oth_rdy, bus.mem_req_addr, bus.mem_req_write, exp_addr, exp_dc);
    end
    cyc();
    bus.mem_req_ready = 1'b0;
    if (drop) begin
      if (exp_dc) bus.dc_req_valid = 1'b0;
      else        bus.ic_req_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = base + DW'(i);
      #1;
      own_rv = exp_dc ? bus.dc_rvalid : bus.ic_rvalid;
      oth_rv = exp_dc ? bus.ic_rvalid : bus.dc_rvalid;
      own_rd = exp_dc ? bus.dc_rdata  : bus.ic_rdata;
      checks++;
      if (own_rv !== 1'b1 || oth_rv !== 1'b0 || own_rd !== base + DW'(i)) begin
        failures++;
        $display("FAIL rd_beat%0d own_rv=%b oth_rv=%b data=%h exp 1 0 %h (dc=%0d)",
                 i, own_rv, oth_rv, own_rd, base + DW'(i), exp_dc);
      end
      cyc();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    #1;
    own_dn = exp_dc ? bus.dc_done : bus.ic_done;
    oth_dn = exp_dc ? bus.ic_done : bus.dc_done;
    checks++;
    if (own_dn !== 1'b1 || oth_dn !== 1'b0) begin
      failures++; $display("FAIL rd_done own=%b oth=%b exp 1 0 (dc=%0d)", own_dn, oth_dn, exp_dc);
    end
    cyc();
    checks++;
    if (bus.ic_done !== 1'b0 || bus.dc_done !== 1'b0) begin
      failures++; $display("FAIL done_pulse ic=%b dc=%b exp 0 0", bus.ic_done, bus.dc_done);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    #1;
    checks++;
    if ({bus.mem_req_valid, bus.mem_req_write, bus.mem_wvalid, bus.ic_req_ready,
         bus.dc_req_ready, bus.ic_rvalid, bus.dc_rvalid, bus.ic_done, bus.dc_done,
         bus.dc_wready, bus.proto_err} !== 11'b0 ||
        bus.mem_req_addr !== '0 || bus.mem_wdata !== '0 ||
        bus.ic_rdata !== '0 || bus.dc_rdata !== '0) begin
      failures++;
      $display("FAIL reset_outputs req_v=%b addr=%h wv=%b perr=%b exp all 0",
               bus.mem_req_valid, bus.mem_req_addr, bus.mem_wvalid, bus.proto_err);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_ic_read();
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = AW'(26'h100);
    rd_burst(1'b0, AW'(26'h100), 32'hA0, 0, 1'b1);
  endtask

  task automatic test_round_robin();
    test_reset();
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = AW'(26'h100);
    bus.dc_req_valid = 1'b1;
    bus.dc_req_write = 1'b0;
    bus.dc_req_addr  = AW'(26'h200);
    rd_burst(1'b1, AW'(26'h200), 32'hD0, 0, 1'b0);
    rd_burst(1'b0, AW'(26'h100), 32'hC0, 0, 1'b0);
    rd_burst(1'b1, AW'(26'h200), 32'hD4, 0, 1'b0);
    bus.dc_req_valid = 1'b0;
    rd_burst(1'b0, AW'(26'h100), 32'hC4, 0, 1'b1);
  endtask

  task automatic test_write_burst();
    int k;
    int pulses;
    k = 0;
    pulses = 0;
    bus.dc_req_valid = 1'b1;
    bus.dc_req_write = 1'b1;
    bus.dc_req_addr  = AW'(26'h2C0);
    bus.mem_req_ready = 1'b1;
    cyc();
    #1;
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b1 ||
        bus.mem_req_addr !== AW'(26'h2C0) || bus.dc_req_ready !== 1'b1 || bus.ic_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL wr_addr valid=%b wr=%b addr=%h dcr=%b icr=%b exp 1 1 2c0 1 0",
               bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr, bus.dc_req_ready, bus.ic_req_ready);
    end
    cyc();
    bus.dc_req_valid  = 1'b0;
    bus.dc_req_write  = 1'b0;
    bus.mem_req_ready = 1'b0;
    for (int t = 0; t < 16 && k < 4; t++) begin
      bus.mem_wready = (t % 2 == 0);
      bus.dc_wdata   = 32'h11 + DW'(k);
      #1;
      checks++;
      if (bus.mem_wvalid !== 1'b1 || bus.mem_wdata !== 32'h11 + DW'(k) ||
          bus.dc_wready !== bus.mem_wready || bus.dc_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL wr_beat t=%0d wv=%b wdata=%h wrdy=%b exp 1 %h %b",
                 t, bus.mem_wvalid, bus.mem_wdata, bus.dc_wready, 32'h11 + DW'(k), bus.mem_wready);
      end
      if (bus.dc_wready === 1'b1) pulses++;
      if (bus.mem_wready) k++;
      cyc();
    end
    bus.mem_wready = 1'b0;
    bus.dc_wdata   = '0;
    checks++;
    if (pulses != 4 || k != 4) begin
      failures++; $display("FAIL wr_pulses got=%0d beats=%0d exp 4", pulses, k);
    end
    #1;
    checks++;
    if (bus.dc_done !== 1'b1 || bus.ic_done !== 1'b0 || bus.mem_wvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr_done dc=%b ic=%b wv=%b exp 1 0 0", bus.dc_done, bus.ic_done, bus.mem_wvalid);
    end
    cyc();
  endtask

  task automatic test_addr_stall();
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = AW'(26'h180);
    rd_burst(1'b0, AW'(26'h180), 32'hE0, 5, 1'b1);
  endtask

  task automatic test_mid_burst_reset();
    bus.ic_req_valid  = 1'b1;
    bus.ic_req_addr   = AW'(26'h140);
    bus.mem_req_ready = 1'b1;
    cyc();
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.ic_req_valid  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hF0 + DW'(i);
      cyc();
    end
    bus.mem_rdata = 32'hF2;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    #1;
    checks++;
    if ({bus.mem_req_valid, bus.ic_rvalid, bus.dc_rvalid, bus.ic_done, bus.dc_done,
         bus.mem_wvalid, bus.proto_err} !== 7'b0 || bus.ic_rdata !== '0 || bus.mem_req_addr !== '0) begin
      failures++;
      $display("FAIL midreset_outputs req_v=%b ic_rv=%b ic_dn=%b perr=%b rdata=%h exp all 0",
               bus.mem_req_valid, bus.ic_rvalid, bus.ic_done, bus.proto_err, bus.ic_rdata);
    end
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = AW'(26'h140);
    rd_burst(1'b0, AW'(26'h140), 32'hB0, 0, 1'b1);
  endtask

  task automatic test_proto_err();
    test_reset();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h55;
    #1;
    checks++;
    if (bus.ic_rvalid !== 1'b0 || bus.dc_rvalid !== 1'b0 || bus.ic_rdata !== '0 || bus.dc_rdata !== '0) begin
      failures++;
      $display("FAIL stray_fwd ic_rv=%b dc_rv=%b ic_rd=%h dc_rd=%h exp 0",
               bus.ic_rvalid, bus.dc_rvalid, bus.ic_rdata, bus.dc_rdata);
    end
    cyc();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    #1;
    checks++;
    if (bus.proto_err !== 1'b1) begin
      failures++; $display("FAIL proto_err_set got=%b exp=1", bus.proto_err);
    end
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = AW'(26'h300);
    rd_burst(1'b0, AW'(26'h300), 32'h70, 0, 1'b1);
    #1;
    checks++;
    if (bus.proto_err !== 1'b1) begin
      failures++; $display("FAIL proto_err_sticky got=%b exp=1", bus.proto_err);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clear_inputs();
    test_reset();
    test_ic_read();
    test_round_robin();
    test_write_burst();
    test_addr_stall();
    test_mid_burst_reset();
    test_proto_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
